// File: rtl/ascon_perm_seq_pkg.sv
// rtl/ascon_perm_seq_pkg.sv - shared constants, FSM encoding and round helpers for the Ascon sequencer
//
// Purpose: package ascon_pkg, imported by the round datapath and the sequencer.
//   STATE_W / LANE_W / ROUNDS_MAX  : geometry of the 320-bit Ascon state
//   fsm_t, IDLE/RUN/DONE           : sequencer state encoding
//   rc()                           : round constant for round index i
//   get_lane() / pack_lanes()      : lane slicing, x0 in the top 64 bits
//   rotr()                         : 64-bit rotate right
//   start_rnd()                    : first round index for a requested round count
package ascon_pkg;

  localparam int STATE_W    = 320;
  localparam int LANE_W     = 64;
  localparam int ROUNDS_MAX = 12;

  typedef logic [1:0] fsm_t;
  localparam fsm_t IDLE = 2'd0;
  localparam fsm_t RUN  = 2'd1;
  localparam fsm_t DONE = 2'd2;

  function automatic logic [7:0] rc(input logic [3:0] i);
    return {4'hF - i, i};
  endfunction

  function automatic logic [LANE_W-1:0] get_lane(input logic [STATE_W-1:0] s, input int k);
    return s[STATE_W-1-LANE_W*k -: LANE_W];
  endfunction

  function automatic logic [STATE_W-1:0] pack_lanes(
    input logic [LANE_W-1:0] a0, input logic [LANE_W-1:0] a1, input logic [LANE_W-1:0] a2,
    input logic [LANE_W-1:0] a3, input logic [LANE_W-1:0] a4);
    return {a0, a1, a2, a3, a4};
  endfunction

  function automatic logic [LANE_W-1:0] rotr(input logic [LANE_W-1:0] x, input int n);
    return (x >> n) | (x << (LANE_W - n));
  endfunction

  // p^n always finishes on round 11, so it starts at 12 - n; out-of-range counts mean p^12.
  function automatic logic [3:0] start_rnd(input logic [3:0] n);
    if (n == 4'd0 || n > 4'd12) return 4'd0;
    return 4'(ROUNDS_MAX) - n;
  endfunction

endpackage

// File: rtl/ascon_perm_seq_if.sv
// rtl/ascon_perm_seq_if.sv - request/response handshake bundle for the Ascon sequencer
//
// Purpose: groups both valid/ready channels of the sequencer.
//   in_valid/in_ready/in_state/in_rounds : request channel (master -> slave)
//   out_valid/out_ready/out_state        : response channel (slave -> master)
// Modports: master (mode controller side), slave (sequencer side).
interface ascon_perm_seq_if #(
  parameter int BW = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [5*BW-1:0] in_state;
  logic [3:0]      in_rounds;
  logic            out_valid;
  logic            out_ready;
  logic [5*BW-1:0] out_state;

  modport master (
    output in_valid, in_state, in_rounds, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, in_rounds, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/ascon_perm_seq_round.sv
// rtl/ascon_perm_seq_round.sv - combinational single Ascon round
//
// Purpose: one Ascon round: constant addition, bitsliced 5-bit S-box, linear layer.
// Ports:
//   i_state : 320-bit input state (x0 in the top lane)
//   i_rnd   : round index 0..11 selecting the round constant
//   o_state : 320-bit output state
module ascon_round
  import ascon_pkg::*;
(
  input  logic [STATE_W-1:0] i_state,
  input  logic [3:0]         i_rnd,
  output logic [STATE_W-1:0] o_state
);

  logic [LANE_W-1:0] x0, x1, x2, x3, x4;
  logic [LANE_W-1:0] t0, t1, t2, t3, t4;

  always_comb begin
    x0 = get_lane(i_state, 0);
    x1 = get_lane(i_state, 1);
    x2 = get_lane(i_state, 2);
    x3 = get_lane(i_state, 3);
    x4 = get_lane(i_state, 4);

    x2 = x2 ^ {{(LANE_W-8){1'b0}}, rc(i_rnd)};

    // Bitsliced S-box: each bit column across x0..x4 is one 5-bit S-box input.
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
    x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
    x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
    x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
    x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);

    o_state = pack_lanes(x0, x1, x2, x3, x4);
  end

endmodule

// File: rtl/ascon_perm_seq.sv
// rtl/ascon_perm_seq.sv - round sequencer iterating the Ascon round datapath
//
// Purpose: accepts a state and round count n, applies rounds 12-n..11 with the
// state fed back each clock, then presents the result until it is taken.
// Ports:
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset
//   bus  : ascon_perm_seq_if.slave request/response channels
//   busy : high while rounds are being applied
// Build option: ASCON_PERM_UNROLL2_EN chains two round instances, applying two
// rounds per clock while at least two remain.
module ascon_perm_seq
  import ascon_pkg::*;
#(
  parameter int BW = LANE_W
)
(
  input  logic             clk,
  input  logic             rstn,
  ascon_perm_seq_if.slave  bus,
  output logic             busy
);

  fsm_t            r_fsm;
  logic [5*BW-1:0] r_state;
  logic [3:0]      r_rnd;

  logic [5*BW-1:0] w_r0;
  logic [5*BW-1:0] w_next;
  logic [3:0]      w_step;
  logic            w_last;

  ascon_round u_round0 (
    .i_state (r_state),
    .i_rnd   (r_rnd),
    .o_state (w_r0)
  );

`ifdef ASCON_PERM_UNROLL2_EN
  logic [3:0]      w_rnd1;
  logic [5*BW-1:0] w_r1;

  assign w_rnd1 = r_rnd + 4'd1;

  ascon_round u_round1 (
    .i_state (w_r0),
    .i_rnd   (w_rnd1),
    .o_state (w_r1)
  );

  // Two rounds fit while the pair (rnd, rnd+1) ends at or before round 11.
  assign w_next = (r_rnd <= 4'd10) ? w_r1 : w_r0;
  assign w_step = (r_rnd <= 4'd10) ? 4'd2 : 4'd1;
  assign w_last = (r_rnd >= 4'd10);
`else
  assign w_next = w_r0;
  assign w_step = 4'd1;
  assign w_last = (r_rnd == 4'd11);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fsm   <= IDLE;
      r_state <= '0;
      r_rnd   <= '0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (bus.in_valid) begin
            r_state <= bus.in_state;
            r_rnd   <= start_rnd(bus.in_rounds);
            r_fsm   <= RUN;
          end
        end
        RUN: begin
          r_state <= w_next;
          r_rnd   <= r_rnd + w_step;
          if (w_last) r_fsm <= DONE;
        end
        DONE: begin
          if (bus.out_ready) r_fsm <= IDLE;
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  // Handshake flags decode straight from the state register so reset drops them at once.
  assign bus.in_ready  = (r_fsm == IDLE);
  assign bus.out_valid = (r_fsm == DONE);
  assign bus.out_state = r_state;
  assign busy          = (r_fsm == RUN);

endmodule

// File: doc/ascon_perm_seq.md
# ascon_perm_seq

Round sequencer that drives the single-round Ascon permutation datapath. It accepts a 320-bit state and a round count over a valid/ready handshake, then iterates the round function one round per clock with the state fed back each cycle. It returns the permuted state over a second valid/ready handshake. It sits between the mode controllers (AEAD/hash: p^a init/final, p^b data) and the round datapath, and replaces per-round external sequencing of `round`/`s_in`.

## Interface
- `BW`, 64: lane width; state is 5*BW bits, lane x0 at [5*BW-1:4*BW], x4 at [BW-1:0].
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: sequencer can accept; equals (fsm == IDLE).
- `in_state` in 5*BW: state to permute.
- `in_rounds` in 4: number of rounds n; legal 1..12; 0 or >12 is treated as 12.
- `out_valid` out 1: permuted state available.
- `out_ready` in 1: consumer accepts result.
- `out_state` out 5*BW: permuted state; this is the state register.
- `busy` out 1: high in RUN.

## Operation
- FSM states:
  - IDLE -> RUN on `in_valid & in_ready`. On that edge: state reg <= `in_state`, rnd <= 12 - n.
  - RUN: each edge, state reg <= round(state reg, rnd), rnd <= rnd + 1. When the round with rnd == 11 is applied, go to DONE.
  - DONE: `out_valid` = 1. On `out_valid & out_ready`, go to IDLE.
- Round constant for index i (0..11) is {4'hF - i, i[3:0]}, XORed into x2 bits [7:0]. The rest of the round is per the Ascon spec: 5-bit S-box bitsliced across lanes, then linear layer with rotations (19,28), (61,39), (1,6), (10,17), (7,41) on x0..x4.
- `in_state`/`in_rounds` are sampled only on the accept edge; later changes are ignored.
- `out_state` is held stable while `out_valid & !out_ready`.
- No pipelining of requests: `in_ready` is low in RUN and DONE.

## Timing
- Reset values: fsm = IDLE, `in_ready` = 1, `out_valid` = 0, `busy` = 0, `out_state` = 0, rnd = 0.
- Latency: `out_valid` rises exactly n clock edges after the accept edge.
  - n = 12: 12 cycles.
  - n = 8: 8 cycles.
  - n = 6: 6 cycles.
- Throughput: n + 2 edges per permutation (accept, n rounds, output handshake); the next accept happens on the edge after the output handshake.
- `out_ready` held high in DONE: `out_valid` is high for exactly 1 cycle.
- Reset mid-operation: all registers clear immediately (asynchronous). `out_valid` and `busy` drop without waiting for a clock edge; the partial state is discarded.
- n = 1: only round 11 is applied; DONE is reached one edge after accept.

## Configuration
- `ASCON_PERM_UNROLL2_EN` defined: two chained round instances per cycle.
  - Each RUN edge applies rounds rnd and rnd+1 while 11 - rnd >= 1; otherwise a single round.
  - Latency is ceil(n/2) edges (12 -> 6, 6 -> 3, 1 -> 1).
- Undefined: one round per cycle, latency n as above.
- Handshake rules and reset behaviour are identical in both builds.

## Structure
- Package `ascon_pkg`:
  - STATE_W = 320.
  - ROUNDS_MAX = 12.
  - FSM state typedef (IDLE, RUN, DONE).
  - Round-constant function rc(i).
  - Lane-slice helpers.
- Sub-module `ascon_round`: purely combinational single round (inputs state and round index, output state). Instantiated once, or twice under `ASCON_PERM_UNROLL2_EN`. It is also reused by the existing round-datapath bench as a golden check.

## Test plan
- `in_state` = 0, `in_rounds` = 12, `out_ready` = 1 -> `out_valid` exactly 12 edges after accept; `out_state` matches the software p12(0) golden model; `in_ready` back to 1 one edge later.
- `in_rounds` = 6 and 8 with random states -> latency 6 and 8; results match p6/p8 golden. `in_rounds` = 0 and 15 -> behave as 12.
- `out_ready` low for 5 cycles in DONE -> `out_valid` and `out_state` stable for all 5 cycles; `in_valid` pulses are ignored (`in_ready` = 0).
- `in_state` changed during RUN -> result is unaffected (still equal to golden of the accepted state).
- `rstn` asserted mid-RUN at round 4 -> `busy`/`out_valid` go 0 asynchronously; a new request after release yields the correct result.
- Back-to-back: 3 requests with `in_valid` always high -> accepts spaced n + 2 edges apart. Under `ASCON_PERM_UNROLL2_EN`, repeat the 12/6/1-round cases and expect latencies 6/3/1.
